// File: rtl/spi_loopback_miso_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_loopback_miso_arbiter_pkg
// Brief   : Shared types and helpers for the loopback SPI MISO frame arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package spi_loopback_miso_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    // A fill count above the depth borrows into bit 32 and reads as no room.
    function automatic logic fifo_has_room(
        input logic [31:0] i_fill,
        input logic [32:0] i_depth,
        input logic [32:0] i_thresh
    );
        logic [32:0] w_free;
        w_free = i_depth - {1'b0, i_fill};
        if (w_free[32]) begin
            return 1'b0;
        end
        return (w_free >= i_thresh);
    endfunction

endpackage : spi_loopback_miso_arbiter_pkg
`default_nettype wire

// File: rtl/spi_loopback_miso_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_loopback_miso_arbiter_if
// Brief   : Requester AXIS bundle, MISO AXIS output and FIFO fill level.
// Revision: 1.0 - initial release
// ============================================================================
interface spi_loopback_miso_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [8*NUM_REQ-1:0] req_s_tdata;
    logic [NUM_REQ-1:0]   req_s_tvalid;
    logic [NUM_REQ-1:0]   req_s_tlast;
    logic [NUM_REQ-1:0]   req_s_tready;
    logic [7:0]           miso_m_tdata;
    logic                 miso_m_tvalid;
    logic                 miso_m_tready;
    logic [31:0]          miso_write_size;

    // Arbiter view
    modport slave (
        input  req_s_tdata, req_s_tvalid, req_s_tlast, miso_m_tready, miso_write_size,
        output req_s_tready, miso_m_tdata, miso_m_tvalid
    );

    // Producer / FIFO environment view
    modport master (
        output req_s_tdata, req_s_tvalid, req_s_tlast, miso_m_tready, miso_write_size,
        input  req_s_tready, miso_m_tdata, miso_m_tvalid
    );
endinterface : spi_loopback_miso_arbiter_if
`default_nettype wire

// File: rtl/spi_loopback_miso_arbiter_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_pick
// Brief   : Combinational round-robin picker: first request at/after pointer.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant_oh,
    output logic      [PTR_W-1:0] o_grant_idx,
    output logic                  o_valid
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_valid           = 1'b1;
                o_grant_idx       = w_idx;
                o_grant_oh[w_idx] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_pick
`default_nettype wire

// File: rtl/spi_loopback_miso_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_loopback_miso_arbiter
// Brief   : Whole-frame round-robin arbiter feeding the loopback SPI MISO FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module spi_loopback_miso_arbiter
    import spi_loopback_miso_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 512,
    parameter int MAX_FRAME  = 16,
    parameter int CNT_W      = 16,
    parameter int PTR_W      = $clog2(NUM_REQ)
) (
    input  wire logic               clk_core,
    input  wire logic               clk_core_resn,
    input  wire logic               enable,
    spi_loopback_miso_arbiter_if.slave arb_bus,
    output logic      [PTR_W-1:0]   grant_id,
    output logic                    busy,
    output logic                    err_oversize,
    output logic      [CNT_W-1:0]   frames_sent
);

    localparam int BC_W = $clog2(MAX_FRAME + 1);
    localparam logic [BC_W-1:0] C_MAX_BYTES = BC_W'(MAX_FRAME);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [BC_W-1:0]    r_byte_cnt;
    logic [CNT_W-1:0]   r_frames;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_xfer;
    logic               w_g_valid;
    logic               w_g_last;
    logic [7:0]         w_g_data;
    logic               w_hs;
    logic [BC_W-1:0]    w_cnt_inc;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_take;
    logic               w_done;
    logic               w_oversize;

    rr_arbiter_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req       (arb_bus.req_s_tvalid),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx),
        .o_valid     (w_pick_valid)
    );

    always_comb begin
        w_g_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == PTR_W'(i)) begin
                w_g_data = arb_bus.req_s_tdata[8*i +: 8];
            end
        end
    end

    assign w_xfer     = (r_state == ARB_XFER);
    assign w_g_valid  = |(r_grant_oh & arb_bus.req_s_tvalid);
    assign w_g_last   = |(r_grant_oh & arb_bus.req_s_tlast);
    assign w_hs       = w_xfer && w_g_valid && arb_bus.miso_m_tready;
    assign w_cnt_inc  = r_byte_cnt + 1'b1;
    assign w_next_ptr = (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Outputs are gated by the registered state so reset clears them at once.
    assign arb_bus.miso_m_tvalid = w_xfer && w_g_valid;
    assign arb_bus.miso_m_tdata  = w_xfer ? w_g_data : 8'h00;
    assign arb_bus.req_s_tready  = (w_xfer && arb_bus.miso_m_tready) ? r_grant_oh : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_done      = 1'b0;
        w_oversize  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (enable && w_pick_valid &&
                    fifo_has_room(arb_bus.miso_write_size, 33'(FIFO_DEPTH), 33'(MAX_FRAME))) begin
                    w_state_nxt = ARB_XFER;
                    w_take      = 1'b1;
                end
            end
            ARB_XFER: begin
                if (w_hs && (w_g_last || (w_cnt_inc == C_MAX_BYTES))) begin
                    w_state_nxt = ARB_IDLE;
                    w_done      = 1'b1;
                    w_oversize  = !w_g_last;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge clk_core_resn) begin
        if (!clk_core_resn) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_frames   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_oversize;
            if (w_take) begin
                r_grant    <= w_pick_idx;
                r_grant_oh <= w_pick_oh;
                r_byte_cnt <= '0;
            end
            if (w_hs) begin
                r_byte_cnt <= w_cnt_inc;
            end
            if (w_done) begin
                r_frames <= r_frames + 1'b1;
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    assign grant_id     = r_grant;
    assign busy         = w_xfer;
    assign err_oversize = r_err;
    assign frames_sent  = r_frames;

endmodule : spi_loopback_miso_arbiter
`default_nettype wire
